// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA scanout block.
package vga_pkg;

    // Segment of a horizontal line or vertical frame, in scan order.
    typedef enum logic [1:0] {
        SYNC       = 2'd0,
        BACKPORCH  = 2'd1,
        ACTIVE     = 2'd2,
        FRONTPORCH = 2'd3
    } seg_t;

    // Line fetch state.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISPLAY = 2'd2
    } fetch_t;

    // Default 640x480 @ 60 Hz timing (25 MHz pixel clock).
    localparam int unsigned H_SYNC_DEF = 96;
    localparam int unsigned H_BP_DEF   = 48;
    localparam int unsigned H_ACT_DEF  = 640;
    localparam int unsigned H_FP_DEF   = 16;
    localparam int unsigned V_SYNC_DEF = 2;
    localparam int unsigned V_BP_DEF   = 33;
    localparam int unsigned V_ACT_DEF  = 480;
    localparam int unsigned V_FP_DEF   = 10;
    localparam int unsigned SCALE_DEF  = 5;

    // Framebuffer geometry: 128x96 at 1 bpp, 32 pixels per word.
    localparam int unsigned FB_W          = 128;
    localparam int unsigned FB_H          = 96;
    localparam int unsigned WORDS_PER_ROW = FB_W / 32;
    localparam int unsigned FB_WORDS      = WORDS_PER_ROW * FB_H;

    // Segment that follows s; FRONTPORCH wraps back to SYNC.
    function automatic seg_t next_seg(input seg_t s);
        unique case (s)
            SYNC:       next_seg = BACKPORCH;
            BACKPORCH:  next_seg = ACTIVE;
            ACTIVE:     next_seg = FRONTPORCH;
            FRONTPORCH: next_seg = SYNC;
        endcase
    endfunction

endpackage

// File: rtl/vga_out_if.sv
// SRAM word-read port between the scanout engine (master) and the arbiter (slave).
interface vga_out_if;
    logic [31:0] SRAM_data_in;
    logic        SRAM_busy;
    logic        data_en;
    logic [31:0] word_address_dest;
    logic [3:0]  byte_select;

    modport master (
        input  SRAM_data_in,
        input  SRAM_busy,
        output data_en,
        output word_address_dest,
        output byte_select
    );

    modport slave (
        output SRAM_data_in,
        output SRAM_busy,
        input  data_en,
        input  word_address_dest,
        input  byte_select
    );
endinterface

// File: rtl/vga_timing.sv
// Horizontal/vertical segment counters and sync generation.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_SYNC = H_SYNC_DEF,
    parameter int unsigned H_BP   = H_BP_DEF,
    parameter int unsigned H_ACT  = H_ACT_DEF,
    parameter int unsigned H_FP   = H_FP_DEF,
    parameter int unsigned V_SYNC = V_SYNC_DEF,
    parameter int unsigned V_BP   = V_BP_DEF,
    parameter int unsigned V_ACT  = V_ACT_DEF,
    parameter int unsigned V_FP   = V_FP_DEF
) (
    input  logic       clk,
    input  logic       nrst,
    output logic [9:0] h_count,
    output logic [8:0] v_count,
    output seg_t       h_state,
    output seg_t       v_state,
    output logic       h_out,
    output logic       v_out,
    output logic       bp_start,  // next edge enters h BACKPORCH
    output logic       fp_start   // next edge enters h FRONTPORCH
);

    logic [9:0] h_count_q, h_count_d;
    logic [8:0] v_count_q, v_count_d;
    seg_t       h_state_q, h_state_d;
    seg_t       v_state_q, v_state_d;
    logic [9:0] h_len;
    logic [8:0] v_len;
    logic       h_last, v_last, line_end;

    // Length of the segment each counter is currently in.
    always_comb begin
        unique case (h_state_q)
            SYNC:       h_len = 10'(H_SYNC);
            BACKPORCH:  h_len = 10'(H_BP);
            ACTIVE:     h_len = 10'(H_ACT);
            FRONTPORCH: h_len = 10'(H_FP);
        endcase
        unique case (v_state_q)
            SYNC:       v_len = 9'(V_SYNC);
            BACKPORCH:  v_len = 9'(V_BP);
            ACTIVE:     v_len = 9'(V_ACT);
            FRONTPORCH: v_len = 9'(V_FP);
        endcase
    end

    assign h_last   = (h_count_q == h_len - 10'd1);
    assign v_last   = (v_count_q == v_len - 9'd1);
    assign line_end = h_last && (h_state_q == FRONTPORCH);

    // Next-state: h steps every clock, v steps once per line at its last clock.
    always_comb begin
        h_count_d = h_count_q + 10'd1;
        h_state_d = h_state_q;
        v_count_d = v_count_q;
        v_state_d = v_state_q;
        if (h_last) begin
            h_count_d = '0;
            h_state_d = next_seg(h_state_q);
        end
        if (line_end) begin
            v_count_d = v_count_q + 9'd1;
            if (v_last) begin
                v_count_d = '0;
                v_state_d = next_seg(v_state_q);
            end
        end
    end

    // Counter and segment registers.
    always_ff @(posedge clk) begin
        if (nrst) begin
            h_count_q <= '0;
            v_count_q <= '0;
            h_state_q <= SYNC;
            v_state_q <= SYNC;
        end else begin
            h_count_q <= h_count_d;
            v_count_q <= v_count_d;
            h_state_q <= h_state_d;
            v_state_q <= v_state_d;
        end
    end

    assign h_count  = h_count_q;
    assign v_count  = v_count_q;
    assign h_state  = h_state_q;
    assign v_state  = v_state_q;
    assign h_out    = (h_state_q != SYNC);
    assign v_out    = (v_state_q != SYNC);
    assign bp_start = h_last && (h_state_q == SYNC);
    assign fp_start = h_last && (h_state_q == ACTIVE);

endmodule

// File: rtl/vga_out.sv
// VGA scanout: fetches one framebuffer row per active line during h back porch
// into a line buffer, then replicates each source pixel SCALE x SCALE.
module vga_out
    import vga_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BP      = H_BP_DEF,
    parameter int unsigned H_ACT     = H_ACT_DEF,
    parameter int unsigned H_FP      = H_FP_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BP      = V_BP_DEF,
    parameter int unsigned V_ACT     = V_ACT_DEF,
    parameter int unsigned V_FP      = V_FP_DEF,
    parameter int unsigned SCALE     = SCALE_DEF
) (
    input  logic         clk,
    input  logic         nrst,
    vga_out_if.master    sram,
    output logic         h_out,
    output logic         v_out,
    output logic         pixel_data,
    output logic [1:0]   VGA_state,
    output logic [9:0]   h_count,
    output logic [8:0]   v_count,
    output logic [1:0]   h_state,
    output logic [1:0]   v_state
);

    seg_t       h_seg, v_seg;
    logic [9:0] h_cnt;
    logic [8:0] v_cnt;
    logic       bp_start, fp_start;

    vga_timing #(
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .H_ACT  (H_ACT),
        .H_FP   (H_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP),
        .V_ACT  (V_ACT),
        .V_FP   (V_FP)
    ) u_timing (
        .clk      (clk),
        .nrst     (nrst),
        .h_count  (h_cnt),
        .v_count  (v_cnt),
        .h_state  (h_seg),
        .v_state  (v_seg),
        .h_out    (h_out),
        .v_out    (v_out),
        .bp_start (bp_start),
        .fp_start (fp_start)
    );

    fetch_t                            state_q, state_d;
    logic [31:0]                       addr_q, addr_d;
    logic [1:0]                        idx_q, idx_d;
    logic [WORDS_PER_ROW-1:0][31:0]    buf_q, buf_d;
    logic [6:0]                        row;
    logic [31:0]                       row_addr;

    assign row      = 7'(v_cnt / 9'(SCALE));
    assign row_addr = BASE_ADDR + {23'd0, row, 2'b00};

    // Fetch FSM next-state; the buffer is cleared at fetch start so words
    // never captured read back as 0.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        unique case (state_q)
            IDLE: begin
                if (bp_start && (v_seg == ACTIVE)) begin
                    state_d = FETCH;
                    addr_d  = row_addr;
                    idx_d   = '0;
                    buf_d   = '0;
                end
            end
            FETCH: begin
                if (fp_start) begin
                    state_d = IDLE;
                end else if (!sram.SRAM_busy) begin
                    buf_d[idx_q] = sram.SRAM_data_in;
                    addr_d       = addr_q + 32'd1;
                    idx_d        = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = DISPLAY;
                    end
                end
            end
            DISPLAY: begin
                if (fp_start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Fetch FSM, address and line buffer registers.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q <= IDLE;
            addr_q  <= BASE_ADDR;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
        end
    end

    logic [6:0] x;
    logic [4:0] bit_sel;

    // Pixel mux: source column x = h_count / SCALE, MSB of each word leftmost.
    always_comb begin
        x          = 7'(h_cnt / 10'(SCALE));
        bit_sel    = 5'd31 - x[4:0];
        pixel_data = 1'b0;
        if ((h_seg == ACTIVE) && (v_seg == ACTIVE)) begin
            pixel_data = buf_q[x[6:5]][bit_sel];
        end
    end

    assign sram.data_en           = (state_q == FETCH);
    assign sram.word_address_dest = addr_q;
    assign sram.byte_select       = 4'b1111;

    assign VGA_state = state_q;
    assign h_count   = h_cnt;
    assign v_count   = v_cnt;
    assign h_state   = h_seg;
    assign v_state   = v_seg;

endmodule

// File: tb/tb_vga_out.sv
// Bench for vga_out: default horizontal timing, shortened vertical timing
// (2/3/15/2 lines) so several whole frames fit in a short run.
module tb_vga_out;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int H_TOT = 800;
    localparam int V_TOT = 22;
    localparam int F_TOT = H_TOT * V_TOT;

    logic        tb_clk = 1'b0;
    logic        nrst;
    logic        busy;
    logic        h_out, v_out, pixel_data;
    logic [1:0]  VGA_state, h_state, v_state;
    logic [9:0]  h_count;
    logic [8:0]  v_count;
    logic [31:0] mem [0:383];
    logic [31:0] rel;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 tb_clk = ~tb_clk;

    vga_out_if sram_bus ();

    vga_out #(
        .BASE_ADDR (BASE),
        .V_SYNC    (2),
        .V_BP      (3),
        .V_ACT     (15),
        .V_FP      (2)
    ) dut (
        .clk        (tb_clk),
        .nrst       (nrst),
        .sram       (sram_bus),
        .h_out      (h_out),
        .v_out      (v_out),
        .pixel_data (pixel_data),
        .VGA_state  (VGA_state),
        .h_count    (h_count),
        .v_count    (v_count),
        .h_state    (h_state),
        .v_state    (v_state)
    );

    // SRAM model: zero-wait read of the currently addressed word.
    always_comb begin
        rel = sram_bus.word_address_dest - BASE;
        sram_bus.SRAM_data_in = (rel < 32'd384) ? mem[rel[8:0]] : 32'hDEAD_BEEF;
    end
    assign sram_bus.SRAM_busy = busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Step samples k0..k1 (k = posedges since reset release), compare every
    // output with a position-based reference and drive the busy plan.
    task automatic scan(input int k0, input int k1, input string name);
        int e_hc = 0, e_hs = 0, e_vc = 0, e_vs = 0, e_ho = 0;
        int e_vo = 0, e_px = 0, e_de = 0, e_ad = 0, e_fs = 0;
        for (int k = k0; k <= k1; k++) begin
            int hp, ln, f, vl, row, a, ehs, ehc, evs, evc, efs;
            logic [31:0] eaddr;
            logic ede, epx, nb;
            @(negedge tb_clk);
            hp = k % H_TOT;
            ln = (k / H_TOT) % V_TOT;
            f  = k / F_TOT;
            if (hp < 96)       begin ehs = 0; ehc = hp;       end
            else if (hp < 144) begin ehs = 1; ehc = hp - 96;  end
            else if (hp < 784) begin ehs = 2; ehc = hp - 144; end
            else               begin ehs = 3; ehc = hp - 784; end
            if (ln < 2)        begin evs = 0; evc = ln;       end
            else if (ln < 5)   begin evs = 1; evc = ln - 2;   end
            else if (ln < 20)  begin evs = 2; evc = ln - 5;   end
            else               begin evs = 3; evc = ln - 20;  end
            vl    = ln - 5;
            row   = (vl >= 0) ? vl / 5 : 0;
            ede   = 1'b0;
            efs   = 0;
            eaddr = 32'h0;
            nb    = 1'b0;
            if (evs == 2) begin
                if (f == 2 && vl == 1) begin
                    // busy for the whole line: fetch never completes
                    if (hp >= 96 && hp < 784) begin
                        ede = 1'b1; efs = 1; eaddr = BASE + 32'(row * 4);
                    end
                    nb = (hp >= 96);
                end else if (f == 2 && vl == 0) begin
                    // busy for the first 10 fetch clocks
                    if (hp >= 96 && hp < 110) begin
                        ede = 1'b1; efs = 1;
                        eaddr = BASE + 32'(row * 4 + ((hp <= 106) ? 0 : hp - 106));
                    end else if (hp >= 110 && hp < 784) begin
                        efs = 2;
                    end
                    nb = (hp >= 96 && hp <= 105);
                end else begin
                    if (hp >= 96 && hp < 100) begin
                        ede = 1'b1; efs = 1; eaddr = BASE + 32'(row * 4 + hp - 96);
                    end else if (hp >= 100 && hp < 784) begin
                        efs = 2;
                    end
                end
            end
            epx = 1'b0;
            if (evs == 2 && ehs == 2) begin
                a = hp - 144;
                if (f == 0)                 epx = 1'b1;
                else if (f == 2 && vl == 1) epx = 1'b0;
                else if (row == 0)          epx = (a < 5) || (a >= 155 && a < 160);
                else if (row == 1)          epx = (a >= 475 && a < 480);
                else                        epx = (a >= 485 && a < 490);
            end
            if (h_count !== 10'(ehc))       e_hc++;
            if (h_state !== 2'(ehs))        e_hs++;
            if (v_count !== 9'(evc))        e_vc++;
            if (v_state !== 2'(evs))        e_vs++;
            if (h_out !== (ehs != 0))       e_ho++;
            if (v_out !== (evs != 0))       e_vo++;
            if (pixel_data !== epx)         e_px++;
            if (sram_bus.data_en !== ede)   e_de++;
            if (VGA_state !== 2'(efs))      e_fs++;
            if (ede && sram_bus.word_address_dest !== eaddr) e_ad++;
            busy = nb;
        end
        check({name, "_h_count"},   e_hc, 0);
        check({name, "_h_state"},   e_hs, 0);
        check({name, "_v_count"},   e_vc, 0);
        check({name, "_v_state"},   e_vs, 0);
        check({name, "_h_out"},     e_ho, 0);
        check({name, "_v_out"},     e_vo, 0);
        check({name, "_pixel"},     e_px, 0);
        check({name, "_data_en"},   e_de, 0);
        check({name, "_addr"},      e_ad, 0);
        check({name, "_VGA_state"}, e_fs, 0);
    endtask

    task automatic check_reset(input string name);
        check({name, "_h_count"},   32'(h_count), 0);
        check({name, "_v_count"},   32'(v_count), 0);
        check({name, "_h_state"},   32'(h_state), 0);
        check({name, "_v_state"},   32'(v_state), 0);
        check({name, "_VGA_state"}, 32'(VGA_state), 0);
        check({name, "_pixel"},     32'(pixel_data), 0);
        check({name, "_h_out"},     32'(h_out), 0);
        check({name, "_v_out"},     32'(v_out), 0);
        check({name, "_data_en"},   32'(sram_bus.data_en), 0);
        check({name, "_addr"},      sram_bus.word_address_dest, BASE);
    endtask

    initial begin
        nrst = 1'b1;
        busy = 1'b0;
        for (int i = 0; i < 384; i++) mem[i] = 32'hFFFF_FFFF;

        // Reset held for two clocks.
        repeat (2) @(negedge tb_clk);
        check_reset("rst");
        check("rst_byte_select", 32'(sram_bus.byte_select), 32'hF);
        nrst = 1'b0;

        // Frame 0: all-ones framebuffer.
        scan(1, F_TOT, "frame0");

        // Frame 1: sparse pattern across rows 0..2.
        for (int i = 0; i < 384; i++) mem[i] = 32'h0;
        mem[0]  = 32'h8000_0001;  // row 0 word 0: x=0 and x=31
        mem[6]  = 32'h0000_0001;  // row 1 word 2: x=95
        mem[11] = 32'h4000_0000;  // row 2 word 3: x=97
        scan(F_TOT + 1, 2 * F_TOT, "frame1");

        // Frame 2: busy stalls on the first two active lines; then run into
        // frame 3 up to an active pixel that should read 1.
        scan(2 * F_TOT + 1, 3 * F_TOT + 5 * H_TOT + 300, "frame2");
        check("mid_pixel_before_rst", 32'(pixel_data), 1);

        // Reset mid-frame for one clock.
        nrst = 1'b1;
        @(negedge tb_clk);
        check_reset("midrst");
        nrst = 1'b0;
        @(negedge tb_clk);
        check("post_rst_h_count", 32'(h_count), 1);
        check("post_rst_v_count", 32'(v_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_out.md
Name: vga_out

Overview:
- 640x480 @ 60 Hz VGA timing generator and 1-bit-per-pixel scanout engine, driven by a 25 MHz pixel clock.
- Reads a 128x96 monochrome framebuffer (384 x 32-bit words) from SRAM; each source pixel is replicated 5x horizontally and 5x vertically.
- Sits between the SRAM arbiter (word read port) and the VGA connector (h_out, v_out, pixel_data).

Parameters:
- BASE_ADDR, 32'h0, word address of framebuffer word 0
- H_SYNC/H_BP/H_ACT/H_FP, 96/48/640/16, horizontal segment lengths in clocks
- V_SYNC/V_BP/V_ACT/V_FP, 2/33/480/10, vertical segment lengths in lines
- SCALE, 5, pixel replication factor

Ports:
- clk  in  1  pixel clock (25 MHz)
- nrst  in  1  reset; one clock; reset is synchronous and active-high
- SRAM_data_in  in  32  read data for word_address_dest; sampled when data_en=1 and SRAM_busy=0
- SRAM_busy  in  1  SRAM not ready; hold the request
- data_en  out  1  read request
- word_address_dest  out  32  requested word address
- byte_select  out  4  constant 4'b1111
- h_out  out  1  HSYNC, active low
- v_out  out  1  VSYNC, active low
- pixel_data  out  1  pixel output
- VGA_state  out  2  fetch FSM state: 0 IDLE, 1 FETCH, 2 DISPLAY
- h_count  out  10  clocks elapsed in the current h segment
- v_count  out  9  lines elapsed in the current v segment
- h_state  out  2  0 SYNC, 1 BACKPORCH, 2 ACTIVE, 3 FRONTPORCH
- v_state  out  2  same encoding as h_state

Behaviour:
- Reset (nrst=1 at a posedge):
  - h_count=0, v_count=0, h_state=SYNC, v_state=SYNC, VGA_state=IDLE.
  - data_en=0, word_address_dest=BASE_ADDR, line buffer cleared, pixel_data=0.
- Horizontal counter:
  - h_count increments every clock.
  - At h_count=len-1 of the current segment: h_count goes to 0 and h_state advances SYNC->BACKPORCH->ACTIVE->FRONTPORCH->SYNC.
  - Line total: 800 clocks.
- Vertical counter:
  - Steps only on the clock where h_state=FRONTPORCH and h_count=15 (end of line).
  - v_count increments; at len-1 it wraps to 0 and v_state advances through the same sequence.
  - Frame total: 525 lines.
  - The 2-line SYNC segment: v_count reads 0 on the first line and 1 on the second.
- Sync outputs: combinational, h_out = (h_state!=SYNC), v_out = (v_state!=SYNC).
- Fetch FSM:
  - IDLE -> FETCH on entry to h BACKPORCH when v_state=ACTIVE.
  - FETCH reads 4 words into a 128-bit line buffer: word k at BASE_ADDR + row*4 + k, where row = v_count/5 (0..95).
  - data_en=1 throughout FETCH. A word is captured on each clock with SRAM_busy=0, then the address advances.
  - After word 3 is captured: FETCH -> DISPLAY.
  - DISPLAY -> IDLE on entry to h FRONTPORCH.
  - Words not captured by the start of ACTIVE display as 0.
  - A fetch still pending at FRONTPORCH entry is abandoned and the FSM returns to IDLE.
- Pixel output:
  - In h ACTIVE and v ACTIVE: x = h_count/5 (0..127); pixel_data = word x[6:5], bit 31 - x[4:0] (MSB = leftmost pixel).
  - Otherwise pixel_data = 0.
- Reset mid-frame returns every output to its reset value on the next posedge.
- All counters and state are registered; pixel_data has no added latency relative to h_count.

Decomposition:
- vga_pkg holds:
  - seg_t enum (SYNC, BACKPORCH, ACTIVE, FRONTPORCH) and fetch_t enum (IDLE, FETCH, DISPLAY).
  - Default timing constants.
  - Framebuffer geometry: 128x96, 4 words/row, 384 words.
- Sub-module vga_timing: h/v counters, segment FSMs, sync outputs.
- vga_out: instantiates vga_timing and contains the fetch FSM, line buffer and pixel mux.

Test Plan:
- Hold nrst=1 for 2 clocks -> h_count=0, v_count=0, h_state=0, v_state=0, VGA_state=0, pixel_data=0, h_out=0, v_out=0. One clock after release -> h_count=1.
- Free-run one line -> h_count runs 0..95, 0..47, 0..639, 0..15 with h_state 0,1,2,3. h_out low only during the first 96 clocks. v_count=1 after 800 clocks.
- Free-run one frame -> v segments last 2/33/480/10 lines; v_out low only during the first 1600 clocks; the frame repeats at 420000 clocks.
- Memory all 32'hFFFFFFFF, SRAM_busy=0 -> pixel_data=1 exactly in h ACTIVE and v ACTIVE, 0 elsewhere. data_en asserted for 4 clocks at each active line's BACKPORCH start, addresses row*4..row*4+3.
- Word 0 of row 0 = 32'h80000001, other words 0 -> on v active lines 0..4, pixel_data=1 for active clocks 0..4 and 155..159 only.
- SRAM_busy=1 for 10 clocks at fetch start -> address and data_en held; 4 words captured afterwards; display correct. With busy held all of BACKPORCH -> active line outputs 0 and VGA_state returns to 0 at FRONTPORCH.
